// File: rtl/store_data_buffer.sv
// store_data_buffer: FIFO of lane-aligned stores between the MEM stage and data memory.
// Optional tail-entry store merging is enabled by defining STORE_MERGE_EN.
module store_data_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [31:0]                st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 store_option,
  output logic                       mem_wvalid,
  input  logic                       mem_wready,
  output logic [31:0]                mem_waddr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       misalign,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [AW-1:0] head, tail, last;
  logic [LW-1:0] cnt;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          mis, acc, push, pop, merge;
  always_comb begin
    wdata = store_option == 3'b000 ? {4{st_data[7:0]}} :
            store_option == 3'b001 ? {2{st_data[15:0]}} : st_data;
    wstrb = store_option == 3'b000 ? 4'b0001 << st_addr[1:0] :
            store_option == 3'b001 ? 4'b0011 << st_addr[1:0] : 4'b1111;
    mis   = store_option == 3'b001 ? st_addr[0] :
            store_option == 3'b010 ? |st_addr[1:0] : store_option != 3'b000;
  end
  assign last = tail - AW'(1);
`ifdef STORE_MERGE_EN
  // Tail is only mergeable when it is not the head, so a pending memory write never changes.
  assign merge = st_valid && !mis && cnt >= LW'(2) && addr_q[last] == st_addr[31:2];
`else
  assign merge = 1'b0;
`endif
  assign st_ready   = cnt < FULL || merge;
  assign acc        = st_valid && st_ready;
  assign push       = acc && !mis && !merge;
  assign pop        = mem_wvalid && mem_wready;
  assign mem_wvalid = cnt != '0;
  assign mem_waddr  = {addr_q[head], 2'b00};
  assign mem_wdata  = data_q[head];
  assign mem_wstrb  = strb_q[head];
  assign level      = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      misalign <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      cnt      <= cnt + LW'(push) - LW'(pop);
      misalign <= acc && mis;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= st_addr[31:2];
      data_q[tail] <= wdata;
      strb_q[tail] <= wstrb;
    end
    if (merge) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) data_q[last][8*i +: 8] <= wdata[8*i +: 8];
      strb_q[last] <= strb_q[last] | wstrb;
    end
  end
endmodule

// File: tb/tb_store_data_buffer.sv
// tb_store_data_buffer: directed and random stores checked against a queue-based reference model.
module tb_store_data_buffer;
  localparam int DEPTH = 4;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } entry_t;
  logic clk = 0, rst = 1, st_valid = 0, mem_wready = 0;
  logic [31:0] st_addr = 0, st_data = 0;
  logic [2:0] store_option = 0;
  logic st_ready, mem_wvalid, misalign;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [$clog2(DEPTH):0] level;
  entry_t mq[$];
  logic exp_mis = 0, started = 0, hs = 0;
  int total = 0, bad = 0;
  store_data_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .store_option(store_option),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .misalign(misalign), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic is_mis(input logic [31:0] a, input logic [2:0] o);
    if (o == 0) return 0;
    if (o == 1) return a % 2 != 0;
    if (o == 2) return a % 4 != 0;
    return 1;
  endfunction
  function automatic entry_t mk(input logic [31:0] a, input logic [31:0] d, input logic [2:0] o);
    entry_t e;
    e.addr = a & 32'hFFFF_FFFC;
    if (o == 0) begin
      e.data = (d & 32'hFF) * 32'h0101_0101;
      e.strb = 4'(1 << (a % 4));
    end else if (o == 1) begin
      e.data = (d & 32'hFFFF) * 32'h0001_0001;
      e.strb = 4'(3 << (a % 4));
    end else begin
      e.data = d;
      e.strb = 4'hF;
    end
    return e;
  endfunction
  function automatic logic eligible(input logic [31:0] a, input logic [2:0] o);
`ifdef STORE_MERGE_EN
    return !is_mis(a, o) && mq.size() >= 2 && mq[mq.size()-1].addr == (a & 32'hFFFF_FFFC);
`else
    return 0;
`endif
  endfunction
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] o, input logic wr, input logic r = 0);
    entry_t e;
    logic rexp, acc, elig;
    @(negedge clk);
    rst = r; st_valid = v; st_addr = a; st_data = d; store_option = o; mem_wready = wr;
    #2;
    elig = v && eligible(a, o);
    rexp = mq.size() < DEPTH || elig;
    if (!r && started) chk("st_ready", st_ready, rexp);
    acc = v && rexp && !r;
    e = mk(a, d, o);
    @(posedge clk);
    if (r) begin
      mq.delete();
      exp_mis = 0;
    end else begin
      exp_mis = acc && is_mis(a, o);
      if (acc && !is_mis(a, o)) begin
        if (elig) begin
          entry_t t = mq[mq.size()-1];
          logic [31:0] m = 0;
          for (int i = 0; i < 4; i++) if (e.strb[i]) m = m | (32'hFF << (8 * i));
          t.data = (t.data & ~m) | (e.data & m);
          t.strb = t.strb | e.strb;
          mq[mq.size()-1] = t;
        end else mq.push_back(e);
      end
    end
  endtask
  always begin
    @(negedge clk);
    #1;
    hs = 0;
    if (started) begin
      chk("level", 32'(level), mq.size());
      chk("mem_wvalid", 32'(mem_wvalid), 32'(mq.size() != 0));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      if (mq.size() != 0) begin
        chk("mem_waddr", mem_waddr, mq[0].addr);
        chk("mem_wdata", mem_wdata, mq[0].data);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(mq[0].strb));
      end
      hs = mem_wvalid && mem_wready && !rst;
    end
    @(posedge clk);
    if (hs && mq.size() != 0) void'(mq.pop_front());
  end
  initial begin
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    started = 1;
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h1003, 32'hAB, 3'b000, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h2002, 32'h1234_5678, 3'b010, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010, 0);
    cycle(1, 32'h110, 32'hA4, 3'b010, 1);
    cycle(1, 32'h110, 32'hA4, 3'b010, 1);
    repeat (6) cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h200, 32'h11, 3'b010, 0);
    cycle(1, 32'h204, 32'h22, 3'b010, 0);
    for (int i = 0; i < 6; i++) cycle(1, 32'h300 + 32'(4 * i), 32'h30 + 32'(i), 3'b010, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 32'h400 + 32'(2 * i), 32'h55 + 32'(i), 3'b001, 0);
    cycle(0, 0, 0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    cycle(1, 32'h10, 32'hDEAD_BEEF, 3'b010, 0);
    cycle(1, 32'h20, 32'h11, 3'b000, 0);
    cycle(1, 32'h21, 32'h22, 3'b000, 0);
    cycle(0, 0, 0, 0, 0);
    #1;
`ifdef STORE_MERGE_EN
    chk("merge_level", 32'(level), 2);
`else
    chk("merge_level", 32'(level), 3);
`endif
    repeat (5) cycle(0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] o;
      o = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      cycle(($urandom % 10) < 6, 32'h40 + 32'($urandom_range(0, 15)), $urandom, o,
            $urandom % 2 == 1, $urandom % 250 == 0);
    end
    repeat (2 * DEPTH) cycle(0, 0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
